// File: rtl/gaussian_stream_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : gaussian_stream_wrapper
// Purpose  : Frame-aware valid/ready wrapper around a fixed-latency Gaussian
//            core: drops warm-up results, flushes the tail, buffers in a FIFO.
// Revision : 1.0
// ============================================================================
module gaussian_stream_wrapper #(
  parameter int DW         = 8,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int KSIZE      = 5,
  parameter int CORE_LAT   = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_sof,
  input  logic [DW-1:0]               in_data,
  output logic                        in_ready,
  output logic                        core_en,
  output logic [DW-1:0]               core_din,
  input  logic [DW-1:0]               core_dout,
  output logic                        out_valid,
  output logic [DW-1:0]               out_data,
  input  logic                        out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        frame_done,
  output logic                        sof_err
);

  localparam int C_PRIME = (KSIZE/2)*IMG_W + KSIZE/2 + CORE_LAT;
  localparam int C_NPIX  = IMG_W*IMG_H;
  localparam int C_PIX_W = $clog2(C_NPIX+1);
  localparam int C_PRM_W = $clog2(C_PRIME+1);
  localparam int C_AW    = $clog2(FIFO_DEPTH);
  localparam int C_LW    = C_AW + 1;

  localparam logic [C_PIX_W-1:0] C_PIX_LAST = C_PIX_W'(C_NPIX-1);
  localparam logic [C_PRM_W-1:0] C_PRM_LAST = C_PRM_W'(C_PRIME-1);
  localparam logic [C_LW-1:0]    C_FULL     = C_LW'(FIFO_DEPTH);

  generate
    if ((C_PRIME >= C_NPIX) || (KSIZE < 3) || (KSIZE % 2 == 0) ||
        (FIFO_DEPTH < 2) || ((1 << C_AW) != FIFO_DEPTH)) begin : g_bad_params
      $error("gaussian_stream_wrapper: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_STREAM = 2'd2,
    S_FLUSH  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [C_PIX_W-1:0]   pix_q, pix_d;
  logic [C_PRM_W-1:0]   prm_q, prm_d;      // prime count, reused as flush count
  logic                 sof_err_q, sof_err_d;
  logic                 done_q, done_d;
  logic [C_AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [C_LW-1:0]      level_q, level_d;
  logic [DW-1:0]        mem_q [FIFO_DEPTH];
  logic [DW-1:0]        mem_d [FIFO_DEPTH];

  logic                 full, ready, step_en, push, pop;
  logic [DW-1:0]        step_din;

  assign full = (level_q == C_FULL);

  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    prm_d     = prm_q;
    sof_err_d = sof_err_q;
    done_d    = 1'b0;
    ready     = 1'b0;
    step_en   = 1'b0;
    step_din  = '0;
    push      = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (in_valid) begin
          if (in_sof) begin
            step_en  = 1'b1;
            step_din = in_data;
            state_d  = S_PRIME;
            pix_d    = C_PIX_W'(1);
            prm_d    = C_PRM_W'(1);
          end else begin
            sof_err_d = 1'b1;
          end
        end
      end
      S_PRIME, S_STREAM: begin
        ready = !full;
        if (in_valid && !full) begin
          step_en  = 1'b1;
          step_din = in_data;
          // An early SOF restarts priming; the restart pixel is pixel 1, not an output.
          if (in_sof) begin
            sof_err_d = 1'b1;
            state_d   = S_PRIME;
            pix_d     = C_PIX_W'(1);
            prm_d     = C_PRM_W'(1);
          end else if (state_q == S_PRIME) begin
            pix_d = pix_q + C_PIX_W'(1);
            prm_d = prm_q + C_PRM_W'(1);
            if (prm_q == C_PRM_LAST) state_d = S_STREAM;
          end else begin
            push  = 1'b1;
            pix_d = pix_q + C_PIX_W'(1);
            if (pix_q == C_PIX_LAST) begin
              state_d = S_FLUSH;
              prm_d   = '0;
            end
          end
        end
      end
      S_FLUSH: begin
        if (!full) begin
          step_en = 1'b1;
          push    = 1'b1;
          prm_d   = prm_q + C_PRM_W'(1);
          if (prm_q == C_PRM_LAST) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            prm_d   = '0;
            pix_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Core result is sampled before the shift, so push and core_en share a cycle.
  always_comb begin
    pop      = (level_q != '0) && out_ready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = core_dout;
      wr_ptr_d        = wr_ptr_q + C_AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + C_AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + C_LW'(1);
      2'b01:   level_d = level_q - C_LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pix_q     <= '0;
      prm_q     <= '0;
      sof_err_q <= 1'b0;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      mem_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      pix_q     <= pix_d;
      prm_q     <= prm_d;
      sof_err_q <= sof_err_d;
      done_q    <= done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      mem_q     <= mem_d;
    end
  end

  // Handshake outputs are gated so they drop the moment reset is asserted.
  assign in_ready   = rst & ready;
  assign core_en    = rst & step_en;
  assign core_din   = rst ? step_din : '0;
  assign out_valid  = (level_q != '0);
  assign out_data   = mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign frame_done = done_q;
  assign sof_err    = sof_err_q;

endmodule
`default_nettype wire

// File: tb/tb_gaussian_stream_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_gaussian_stream_wrapper
// Purpose  : Directed self-checking bench with a 10-deep delay-line core model.
// Revision : 1.0
// ============================================================================
module tb_gaussian_stream_wrapper;

  logic       clk, rst, in_valid, in_sof, in_ready, core_en, out_valid, out_ready;
  logic       frame_done, sof_err;
  logic [7:0] in_data, core_din, core_dout, out_data;
  logic [2:0] fifo_level;

  gaussian_stream_wrapper #(
    .DW(8), .IMG_W(8), .IMG_H(4), .KSIZE(3), .CORE_LAT(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .in_ready(in_ready), .core_en(core_en), .core_din(core_din), .core_dout(core_dout),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fifo_level(fifo_level), .frame_done(frame_done), .sof_err(sof_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] dl [10];
  always @(posedge clk) begin
    if (core_en) begin
      for (int i = 9; i > 0; i--) dl[i] <= dl[i-1];
      dl[0] <= core_din;
    end
  end
  assign core_dout = dl[9];

  int n_vec = 0;
  int n_err = 0;

  int cyc = 0, cen_cnt = 0, flush_cnt = 0, flush_nz = 0, done_cnt = 0;
  int last_push_cyc = 0, done_cyc = 0, prev_level = 0, prev_pop = 0, prev_cen = 0;
  bit have_prev = 1'b0;
  int q_out[$];
  int q_push_cen[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev && (int'(fifo_level) - prev_level + prev_pop) == 1) begin
        q_push_cen.push_back(prev_cen);
        last_push_cyc = cyc - 1;
      end
      prev_cen = 0;
      if (core_en) begin
        cen_cnt++;
        prev_cen = cen_cnt;
        if (!in_ready) begin
          flush_cnt++;
          if (core_din != 8'd0) flush_nz++;
        end
      end
      prev_pop = (out_valid && out_ready) ? 1 : 0;
      if (prev_pop == 1) q_out.push_back(int'(out_data));
      prev_level = int'(fifo_level);
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      have_prev = 1'b1;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail_timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout, expected event", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic send_pixels(input int first, input int n, input bit sof);
    for (int i = 0; i < n; i++) begin
      int k;
      in_valid = 1'b1;
      in_sof   = sof && (i == 0);
      in_data  = 8'(first + i);
      for (k = 0; k < 100 && !in_ready; k++) step();
      if (k == 100) fail_timeout("accept");
      step();
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic wait_done(input bit toggle, output int ready_hi);
    int k;
    ready_hi = 0;
    for (k = 0; k < 300; k++) begin
      if (frame_done) break;
      if (in_ready) ready_hi++;
      if (toggle) out_ready = ~out_ready;
      step();
    end
    if (k == 300) fail_timeout("frame_done");
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 50 && out_valid; k++) step();
    if (out_valid) fail_timeout("drain");
    step();
  endtask

  typedef struct packed {
    int rdy_mode;       // 0: always ready, 1: stall until full, 2: toggle in flush
    int base;
    int exp_stall_acc;
    int exp_outs;
    int exp_first_push;
    int exp_flush;
    int exp_done;
  } vec_t;

  task automatic run_frame(input int vi, input vec_t v);
    int out0, cen0, push0, fl0, nz0, dn0, acc, rdy_hi;
    out0 = q_out.size(); cen0 = cen_cnt; push0 = q_push_cen.size();
    fl0 = flush_cnt; nz0 = flush_nz; dn0 = done_cnt; acc = 0;
    out_ready = 1'b1;
    if (v.rdy_mode == 1) begin
      out_ready = 1'b0;
      for (int c = 0; c < 40; c++) begin
        in_valid = 1'b1;
        in_sof   = (acc == 0);
        in_data  = 8'(v.base + acc);
        if (in_ready) acc++;
        step();
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      check($sformatf("v%0d stall accepts", vi), acc, v.exp_stall_acc);
      check($sformatf("v%0d level at stall", vi), int'(fifo_level), 4);
      check($sformatf("v%0d in_ready at stall", vi), int'(in_ready), 0);
      out_ready = 1'b1;
    end
    send_pixels(v.base + acc, 32 - acc, acc == 0);
    wait_done(v.rdy_mode == 2, rdy_hi);
    check($sformatf("v%0d in_ready in flush", vi), rdy_hi, 0);
    drain();
    check($sformatf("v%0d output count", vi), q_out.size() - out0, v.exp_outs);
    for (int i = 0; i < v.exp_outs; i++)
      if (out0 + i < q_out.size())
        check($sformatf("v%0d out[%0d]", vi, i), q_out[out0 + i], (v.base + i) & 255);
    if (q_push_cen.size() > push0)
      check($sformatf("v%0d first push core_en", vi), q_push_cen[push0] - cen0, v.exp_first_push);
    else
      fail_timeout($sformatf("v%0d first push", vi));
    check($sformatf("v%0d flush steps", vi), flush_cnt - fl0, v.exp_flush);
    check($sformatf("v%0d flush nonzero din", vi), flush_nz - nz0, 0);
    check($sformatf("v%0d done pulses", vi), done_cnt - dn0, v.exp_done);
    check($sformatf("v%0d done after last push", vi), done_cyc - last_push_cyc, 1);
  endtask

  vec_t vecs [3];

  initial begin
    int out0, cen0, sof_cen, found, rh;
    vecs[0] = '{rdy_mode: 0, base: 0,  exp_stall_acc: 0,  exp_outs: 32, exp_first_push: 11, exp_flush: 10, exp_done: 1};
    vecs[1] = '{rdy_mode: 1, base: 50, exp_stall_acc: 14, exp_outs: 32, exp_first_push: 11, exp_flush: 10, exp_done: 1};
    vecs[2] = '{rdy_mode: 2, base: 0,  exp_stall_acc: 0,  exp_outs: 32, exp_first_push: 11, exp_flush: 10, exp_done: 1};

    rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    #2;
    check("reset in_ready", int'(in_ready), 0);
    check("reset core_en", int'(core_en), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset fifo_level", int'(fifo_level), 0);
    check("reset frame_done", int'(frame_done), 0);
    check("reset sof_err", int'(sof_err), 0);
    check("reset out_data", int'(out_data), 0);
    step();
    rst = 1'b1;
    step();
    check("idle in_ready", int'(in_ready), 1);

    for (int vi = 0; vi < 3; vi++) run_frame(vi, vecs[vi]);
    check("sof_err clean frames", int'(sof_err), 0);

    // Pixel without SOF while idle is dropped.
    in_valid = 1'b1; in_sof = 1'b0; in_data = 8'd77;
    check("no-sof core_en", int'(core_en), 0);
    step();
    in_valid = 1'b0;
    check("no-sof sof_err", int'(sof_err), 1);
    check("no-sof fifo_level", int'(fifo_level), 0);
    check("no-sof out_valid", int'(out_valid), 0);

    // Early SOF on pixel 20 restarts the frame.
    do_reset();
    check("post-reset sof_err", int'(sof_err), 0);
    out_ready = 1'b1;
    out0 = q_out.size();
    send_pixels(0, 19, 1'b1);
    sof_cen = cen_cnt + 1;
    send_pixels(100, 32, 1'b1);
    check("early sof sof_err", int'(sof_err), 1);
    wait_done(1'b0, rh);
    drain();
    check("early sof output count", q_out.size() - out0, 41);
    for (int i = 0; i < 41; i++)
      if (out0 + i < q_out.size())
        check($sformatf("early sof out[%0d]", i), q_out[out0 + i], (i < 9) ? i : 100 + i - 9);
    found = -1;
    foreach (q_push_cen[j])
      if (found < 0 && q_push_cen[j] >= sof_cen) found = q_push_cen[j];
    check("early sof first push core_en", found - sof_cen, 10);

    // Asynchronous reset mid-STREAM.
    out_ready = 1'b1;
    cen0 = cen_cnt;
    send_pixels(0, 20, 1'b1);
    in_valid = 1'b1; in_sof = 1'b0; in_data = 8'd20;
    check("pre-rst core_en", int'(core_en), 1);
    check("pre-rst out_valid", int'(out_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    check("async rst in_ready", int'(in_ready), 0);
    check("async rst core_en", int'(core_en), 0);
    check("async rst out_valid", int'(out_valid), 0);
    check("async rst fifo_level", int'(fifo_level), 0);
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    run_frame(3, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
